// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA display blocks.
// Holds the 640x480@60 timing constants, the board tile codes, the tile
// palette and the per-pixel flag bundle that travels down the pipeline.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Counter width; covers both 0..799 and 0..524.
  localparam int CNT_W = 10;

  localparam int TILE_HIDDEN = 9;
  localparam int TILE_FLAG   = 10;
  localparam int TILE_MINE   = 11;

  localparam logic [11:0] PAL_OPEN   = 12'hCCC;
  localparam logic [11:0] PAL_N1     = 12'h00F;
  localparam logic [11:0] PAL_N2     = 12'h0A0;
  localparam logic [11:0] PAL_N3     = 12'hF00;
  localparam logic [11:0] PAL_N4     = 12'h008;
  localparam logic [11:0] PAL_N5     = 12'h800;
  localparam logic [11:0] PAL_N6     = 12'h088;
  localparam logic [11:0] PAL_N7     = 12'h000;
  localparam logic [11:0] PAL_N8     = 12'h888;
  localparam logic [11:0] PAL_HIDDEN = 12'h777;
  localparam logic [11:0] PAL_FLAG   = 12'hFA0;
  localparam logic [11:0] PAL_MINE   = 12'hF0F;
  localparam logic [11:0] PAL_SPARE  = 12'h0FF;
  localparam logic [11:0] COL_OFF    = 12'h000;
  localparam logic [11:0] COL_GRID   = 12'h222;

  typedef struct packed {
    logic active;
    logic hit;
    logic hsync_n;
    logic vsync_n;
    logic frame_start;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_RST = '{active: 1'b0, hit: 1'b0, hsync_n: 1'b1,
                                       vsync_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 horizontal/vertical counters with active and sync
// flags. Reusable by any display block driven by a pixel strobe.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_pix_en          pixel strobe; counters advance only when 1
//   o_hcnt, o_vcnt    current pixel position
//   o_hcnt_nxt/_vnxt  position the counters take at the next clk edge
//                     (equal to the current one when i_pix_en is 0)
//   o_active          current position is in the visible area
//   o_hsync_n/o_vsync_n  active-low sync levels for the current position
module vga_timing
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pix_en,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic [CNT_W-1:0] o_hcnt_nxt,
  output logic [CNT_W-1:0] o_vcnt_nxt,
  output logic             o_active,
  output logic             o_hsync_n,
  output logic             o_vsync_n
);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_vcnt_nxt = r_vcnt;
    if (i_pix_en) begin
      if (r_hcnt == CNT_W'(H_TOTAL - 1)) begin
        w_hcnt_nxt = '0;
        if (r_vcnt == CNT_W'(V_TOTAL - 1)) w_vcnt_nxt = '0;
        else                               w_vcnt_nxt = r_vcnt + 1'b1;
      end else begin
        w_hcnt_nxt = r_hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_pix_en) begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
    end
  end

  assign o_hcnt     = r_hcnt;
  assign o_vcnt     = r_vcnt;
  assign o_hcnt_nxt = w_hcnt_nxt;
  assign o_vcnt_nxt = w_vcnt_nxt;
  assign o_active   = (r_hcnt < CNT_W'(H_ACTIVE)) && (r_vcnt < CNT_W'(V_ACTIVE));
  assign o_hsync_n  = !((r_hcnt >= CNT_W'(H_SYNC_START)) && (r_hcnt < CNT_W'(H_SYNC_END)));
  assign o_vsync_n  = !((r_vcnt >= CNT_W'(V_SYNC_START)) && (r_vcnt < CNT_W'(V_SYNC_END)));

endmodule

// File: rtl/vga_tile_reader.sv
// vga_tile_reader: display-side reader of the Minesweeper board RAM.
// Generates VGA timing, fetches the tile word under each pixel through the
// RAM's read port and drives registered colour and sync for that pixel.
// Optional feature macro: GRID_LINES_EN draws a 1-px 0x222 line on the
// top/left edge of every tile.
// Ports:
//   clk          system clock (RAM reads on its falling edge)
//   rst          asynchronous active-high reset
//   pix_en       pixel strobe; every register advances only when 1
//   mem_addr     registered board-RAM read address
//   mem_data     board-RAM read data, valid one posedge after mem_addr
//   hsync/vsync  active-low syncs
//   rgb          {r,g,b} 4 bits each, 0 outside the board or in blanking
//   frame_start  one-strobe pulse with the output of pixel (0,0)
// Pipeline: S0 counters + mem_addr (addressed from the counters' next
// value so the fetch lines up with the pixel), S1 tile word + flags,
// S2 output registers. Pixel-to-pin latency is two strobes.
module vga_tile_reader
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int BOARD_W       = 5,
  parameter int BOARD_H       = 5,
  parameter int TILE_LOG2     = 5,
  parameter int BOARD_X0      = 240,
  parameter int BOARD_Y0      = 160
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic [11:0]              rgb,
  output logic                     frame_start
);

  localparam int BOARD_X1 = BOARD_X0 + (BOARD_W << TILE_LOG2);
  localparam int BOARD_Y1 = BOARD_Y0 + (BOARD_H << TILE_LOG2);

  function automatic logic [11:0] tile_colour(input logic [3:0] code);
    case (code)
      4'd0:               return PAL_OPEN;
      4'd1:               return PAL_N1;
      4'd2:               return PAL_N2;
      4'd3:               return PAL_N3;
      4'd4:               return PAL_N4;
      4'd5:               return PAL_N5;
      4'd6:               return PAL_N6;
      4'd7:               return PAL_N7;
      4'd8:               return PAL_N8;
      4'(TILE_HIDDEN):    return PAL_HIDDEN;
      4'(TILE_FLAG):      return PAL_FLAG;
      4'(TILE_MINE):      return PAL_MINE;
      default:            return PAL_SPARE;
    endcase
  endfunction

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;
  logic             w_active;
  logic             w_hsync_n;
  logic             w_vsync_n;

  vga_timing u_timing (
    .clk        (clk),
    .rst        (rst),
    .i_pix_en   (pix_en),
    .o_hcnt     (w_hcnt),
    .o_vcnt     (w_vcnt),
    .o_hcnt_nxt (w_hcnt_nxt),
    .o_vcnt_nxt (w_vcnt_nxt),
    .o_active   (w_active),
    .o_hsync_n  (w_hsync_n),
    .o_vsync_n  (w_vsync_n)
  );

  // ---- S0: board hit and address for the pixel the counters move to
  logic [CNT_W-1:0]         w_dx;
  logic [CNT_W-1:0]         w_dy;
  logic [CNT_W-1:0]         w_col;
  logic [CNT_W-1:0]         w_row;
  logic                     w_hit_nxt;
  logic [ADDRESS_WIDTH-1:0] w_addr_nxt;
  logic                     w_origin;

  assign w_dx      = w_hcnt_nxt - CNT_W'(BOARD_X0);
  assign w_dy      = w_vcnt_nxt - CNT_W'(BOARD_Y0);
  assign w_col     = w_dx >> TILE_LOG2;
  assign w_row     = w_dy >> TILE_LOG2;
  assign w_hit_nxt = (w_hcnt_nxt >= CNT_W'(BOARD_X0)) && (w_hcnt_nxt < CNT_W'(BOARD_X1)) &&
                     (w_vcnt_nxt >= CNT_W'(BOARD_Y0)) && (w_vcnt_nxt < CNT_W'(BOARD_Y1));
  assign w_addr_nxt = ADDRESS_WIDTH'(w_row) * ADDRESS_WIDTH'(BOARD_W) + ADDRESS_WIDTH'(w_col);
  assign w_origin   = (w_hcnt == '0) && (w_vcnt == '0);

  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic                     r_hit0;

  // Off-board pixels leave the address alone; their data is masked by hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_hit0     <= 1'b0;
    end else if (pix_en) begin
      r_hit0 <= w_hit_nxt;
      if (w_hit_nxt) r_mem_addr <= w_addr_nxt;
    end
  end

`ifdef GRID_LINES_EN
  logic w_grid_nxt;
  logic r_grid0;
  logic r_grid1;

  assign w_grid_nxt = w_hit_nxt &&
                      ((w_dx[TILE_LOG2-1:0] == '0) || (w_dy[TILE_LOG2-1:0] == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grid0 <= 1'b0;
      r_grid1 <= 1'b0;
    end else if (pix_en) begin
      r_grid0 <= w_grid_nxt;
      r_grid1 <= r_grid0;
    end
  end
`endif

  // ---- S1: tile word (only code and cursor bits matter) plus flags
  logic [4:0]  r_tile1;
  pix_flags_t  r_flags1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile1  <= '0;
      r_flags1 <= FLAGS_RST;
    end else if (pix_en) begin
      r_tile1  <= mem_data[4:0];
      r_flags1 <= '{active: w_active, hit: r_hit0, hsync_n: w_hsync_n,
                    vsync_n: w_vsync_n, frame_start: w_origin};
    end
  end

  // ---- S2: colour decode and output registers
  logic [11:0] w_colour;

  always_comb begin
    w_colour = COL_OFF;
    if (r_flags1.active && r_flags1.hit) begin
      w_colour = tile_colour(r_tile1[3:0]) ^ {12{r_tile1[4]}};
`ifdef GRID_LINES_EN
      if (r_grid1) w_colour = COL_GRID;
`endif
    end
  end

  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_rgb         <= w_colour;
      r_hsync       <= r_flags1.hsync_n;
      r_vsync       <= r_flags1.vsync_n;
      r_frame_start <= r_flags1.frame_start;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign rgb         = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_tile_reader.sv
// Bench for vga_tile_reader. The board is moved near the top of the screen
// with 8-px tiles so the whole board is scanned in a few tens of lines.
module tb_vga_tile_reader;

  localparam int TB_X0 = 240;
  localparam int TB_Y0 = 4;
  localparam int TB_TL = 3;
  localparam int TB_W  = 5;
  localparam int TB_H  = 5;
  localparam int EDGE  = 1 << TB_TL;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_start;

  always #5 clk = ~clk;

  logic [31:0] ram [0:4095];
  always @(negedge clk) mem_data <= ram[mem_addr];

  vga_tile_reader #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .BOARD_W(TB_W), .BOARD_H(TB_H),
    .TILE_LOG2(TB_TL), .BOARD_X0(TB_X0), .BOARD_Y0(TB_Y0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_start(frame_start)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pix_n;
  logic [11:0] m_addr;
  logic [11:0] palette [16];

  function automatic int hpos(int idx); return idx % 800; endfunction
  function automatic int vpos(int idx); return (idx / 800) % 525; endfunction

  function automatic bit on_board(int idx);
    int h = hpos(idx);
    int v = vpos(idx);
    return (h >= TB_X0) && (h < TB_X0 + TB_W * EDGE) && (v >= TB_Y0) && (v < TB_Y0 + TB_H * EDGE);
  endfunction

  function automatic int board_addr(int idx);
    return ((vpos(idx) - TB_Y0) / EDGE) * TB_W + (hpos(idx) - TB_X0) / EDGE;
  endfunction

  function automatic logic [11:0] exp_rgb(int idx);
    logic [31:0] word;
    logic [11:0] c;
    if (hpos(idx) >= 640 || vpos(idx) >= 480 || !on_board(idx)) return 12'h000;
`ifdef GRID_LINES_EN
    if ((hpos(idx) - TB_X0) % EDGE == 0 || (vpos(idx) - TB_Y0) % EDGE == 0) return 12'h222;
`endif
    word = ram[board_addr(idx)];
    c = palette[word[3:0]];
    if (word[4]) c = ~c;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s at pixel %0d: observed=%0h expected=%0h", tag, pix_n, obs, exp);
    end
  endtask

  task automatic check_all();
    int p = pix_n - 2;
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (pix_n >= 2) begin
      chk("rgb", 32'(rgb), 32'(exp_rgb(p)));
      chk("hsync", 32'(hsync), 32'(!(hpos(p) >= 656 && hpos(p) < 752)));
      chk("vsync", 32'(vsync), 32'(!(vpos(p) >= 490 && vpos(p) < 492)));
      chk("frame_start", 32'(frame_start), 32'(hpos(p) == 0 && vpos(p) == 0));
    end else begin
      chk("rgb_pre", 32'(rgb), 32'h0);
      chk("hsync_pre", 32'(hsync), 32'h1);
      chk("vsync_pre", 32'(vsync), 32'h1);
      chk("fs_pre", 32'(frame_start), 32'h0);
    end
  endtask

  task automatic tick(input logic en);
    pix_en = en;
    @(negedge clk);
    if (en) begin
      pix_n++;
      if (on_board(pix_n)) m_addr = 12'(board_addr(pix_n));
    end
    check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk({tag, "_hsync"}, 32'(hsync), 32'h1);
    chk({tag, "_vsync"}, 32'(vsync), 32'h1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    int hs_low;
    int hs_first;
    int blank_bad;
    int p;

    palette = '{12'hCCC, 12'h00F, 12'h0A0, 12'hF00, 12'h008, 12'h800, 12'h088, 12'h000,
                12'h888, 12'h777, 12'hFA0, 12'hF0F, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF};
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    for (int i = 0; i < TB_W * TB_H; i++) ram[i] = $urandom;
    ram[13] = ($urandom & 32'hFFFF_FFE0) | 32'h03;
    ram[0]  = ($urandom & 32'hFFFF_FFE0) | 32'h19;

    rst = 1'b0;
    pix_en = 1'b0;
    pix_n = 0;
    m_addr = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    // Continuous strobe through the whole board, ending at hcnt=300
    hs_low = 0;
    hs_first = -1;
    blank_bad = 0;
    while (pix_n < 46 * 800 + 300) begin
      tick(1'b1);
      if (pix_n >= 802 && pix_n < 1602) begin
        p = pix_n - 2;
        if (!hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = pix_n;
        end
        if (hpos(p) >= 640 && rgb != 12'h000) blank_bad++;
      end
    end
    chk("hsync_low_count", 32'(hs_low), 32'd96);
    chk("hsync_first_low", 32'(hs_first), 32'(800 + 656 + 2));
    chk("blank_rgb_nonzero", 32'(blank_bad), 32'd0);

    // Asynchronous reset in the middle of a line
    chk("pre_reset_hpos", 32'(hpos(pix_n)), 32'd300);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midline");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pix_n = 0;
    m_addr = '0;
    check_all();

    // Strobe 1-in-4: same pixel sequence, outputs held in between
    for (int i = 0; i < 6 * 800; i++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
